control_unit: RTL and testbench
===============================

CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 255: maximum wait cycles for Mem_Ready before a fault.
REQ-002 SHALL have port Fast_Clock, input, 1: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port Reset_n, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port Instruction, input, 32: current instruction word from instruction ROM at PC.
REQ-005 SHALL have port True, input, 1: ALU compare flag.
REQ-006 SHALL have port Mem_Ready, input, 1: data-memory access complete.
REQ-007 SHALL have port In_Valid, input, 1: external input word available.
REQ-008 SHALL have port Resume, input, 1: leave HALT.
REQ-009 SHALL have port Instr_Load, output, 1: latch Instruction into the instruction register.
REQ-010 SHALL have port PC_Write, output, 1: update PC.
REQ-011 SHALL have port PC_Src, output, 2: PC source; 0 = PC+1, 1 = PC+imm16, 2 = jump target[25:0], 3 = register rs.
REQ-012 SHALL have port ALU_Op, output, 5: ALU operation code, 0..18; 17 = NOP, 18 = IMM pass Op2.
REQ-013 SHALL have port ALU_Src, output, 1: Op2 source; 0 = register rt, 1 = sign-extended imm16.
REQ-014 SHALL have port Reg_Write, output, 1: register-file write enable for rd.
REQ-015 SHALL have port Mem_Read, output, 1: data-memory read request.
REQ-016 SHALL have port Mem_Write, output, 1: data-memory write request.
REQ-017 SHALL have port WB_Sel, output, 2: writeback source; 0 = ALU Result, 1 = memory, 2 = input port.
REQ-018 SHALL have port In_Ack, output, 1: one-cycle consume of the input word.
REQ-019 SHALL have port Halted, output, 1: high while in HALT.
REQ-020 SHALL have port Fault, output, 1: one-cycle pulse on an illegal opcode or a memory timeout.

Function
REQ-021 SHALL decode fields as follows: opcode[31:26], rd[25:21], rs[20:16], rt[15:11], imm16[15:0].
REQ-022 SHALL map opcodes 0..16 to R-type with ALU_Op = opcode and ALU_Src = 0; 19 ADDI→ALU_Op 0; 20 SUBI→ALU_Op 1; 21 LI→ALU_Op 18; 22 LW; 23 SW; 24 BT; 25 BF; 26 J; 27 JR; 28 HLT; 29 IN; 17 NOP.
REQ-023 SHALL step FSM states FETCH→DECODE→EXECUTE→{MEMORY|WRITEBACK|FETCH}, plus HALT and WAIT_IN.
REQ-024 SHALL, in FETCH, drive Instr_Load = 1, PC_Write = 1 and PC_Src = 0 for exactly one cycle.
REQ-025 SHALL, in DECODE, drive ALU_Op/ALU_Src from registered outputs so both are stable for all of EXECUTE; the ALU samples on the falling edge.
REQ-026 SHALL give R-type/ADDI/SUBI/LI EXECUTE→WRITEBACK (Reg_Write = 1, WB_Sel = 0) →FETCH, for a total latency of 4 cycles.
REQ-027 SHALL give LW/SW ALU_Op 0 (rs+imm16) in EXECUTE, then MEMORY with Mem_Read/Mem_Write held until Mem_Ready; LW then goes to WRITEBACK (WB_Sel = 1), SW to FETCH.
REQ-028 SHALL sample True at the rising edge ending EXECUTE: BT/BF with ALU_Op 11 take PC_Write = 1, PC_Src = 1 when True is 1 (BT) or 0 (BF); 3-cycle latency.
REQ-029 SHALL give J/JR PC_Write = 1 with PC_Src = 2 or 3 in EXECUTE, then FETCH.
REQ-030 SHALL make IN enter WAIT_IN until In_Valid, then issue In_Ack = 1 with Reg_Write = 1 and WB_Sel = 2 in the same cycle, then FETCH.
REQ-031 SHALL make HLT enter HALT (Halted = 1) until Resume = 1, then FETCH; Resume outside HALT is ignored.
REQ-032 SHALL count MEMORY wait cycles and, when the count reaches MEM_TIMEOUT, drop requests, pulse Fault, go to FETCH with no writeback, and reset the counter on MEMORY entry.
REQ-033 SHALL treat undefined opcodes (18, 30, 31..63) as: pulse Fault in EXECUTE, no writes, then FETCH.
REQ-034 SHALL drive ALU_Op = 17 and all enables low in any state that does not need them.

Reset
REQ-035 SHALL, while Reset_n = 0, immediately set state = FETCH, ALU_Op = 17, all other outputs 0 and the counter 0, even mid-MEMORY or in HALT.
REQ-036 SHALL, on reset release, start its first FETCH on the next rising edge, with reset dominant over Resume, In_Valid and Mem_Ready.

Structure
REQ-037 SHALL place opcode, ALU_Op, PC_Src, WB_Sel and state encodings in shared package cu_pkg.
REQ-038 SHALL implement opcode→class/ALU_Op mapping in combinational sub-module cu_decode; the FSM and counter stay in control_unit.

Verification
REQ-039 SHALL verify ADD (opcode 0): after reset, outputs follow FETCH, DECODE, EXECUTE with ALU_Op = 0 and ALU_Src = 0, then WRITEBACK with Reg_Write = 1 and WB_Sel = 0, then FETCH at cycle 5.
REQ-040 SHALL verify BT with True = 1 at EXECUTE end: PC_Write = 1, PC_Src = 1 in EXECUTE; with True = 0: no PC_Write, next state FETCH.
REQ-041 SHALL verify LW with Mem_Ready after 3 cycles: Mem_Read high for exactly 3 cycles, then WRITEBACK with WB_Sel = 1.
REQ-042 SHALL verify SW with Mem_Ready never asserted and MEM_TIMEOUT = 4: Mem_Write high for 4 cycles, Fault pulses once, no Reg_Write, then FETCH.
REQ-043 SHALL verify HLT then Resume after 10 cycles: Halted high for 10 cycles, then FETCH; Reset_n pulsed low mid-HALT forces ALU_Op = 17 and Halted = 0 asynchronously.
REQ-044 SHALL verify opcode 63: Fault is a one-cycle pulse, no Reg_Write/Mem_Write, and the next instruction is fetched normally.

Source files
------------

// File: rtl/cu_pkg.sv
// Shared encodings for the multi-cycle control unit: opcodes, ALU operation
// codes, PC/writeback source selects, FSM states and instruction classes.
package cu_pkg;

  // Opcodes 0..16 are R-type; the ALU operation equals the opcode.
  localparam logic [5:0] OP_R_LAST = 6'd16;
  localparam logic [5:0] OP_NOP    = 6'd17;
  localparam logic [5:0] OP_ADDI   = 6'd19;
  localparam logic [5:0] OP_SUBI   = 6'd20;
  localparam logic [5:0] OP_LI     = 6'd21;
  localparam logic [5:0] OP_LW     = 6'd22;
  localparam logic [5:0] OP_SW     = 6'd23;
  localparam logic [5:0] OP_BT     = 6'd24;
  localparam logic [5:0] OP_BF     = 6'd25;
  localparam logic [5:0] OP_J      = 6'd26;
  localparam logic [5:0] OP_JR     = 6'd27;
  localparam logic [5:0] OP_HLT    = 6'd28;
  localparam logic [5:0] OP_IN     = 6'd29;

  // ALU operation codes that the control unit issues by name.
  localparam logic [4:0] ALU_ADD = 5'd0;
  localparam logic [4:0] ALU_SUB = 5'd1;
  localparam logic [4:0] ALU_CMP = 5'd11;
  localparam logic [4:0] ALU_NOP = 5'd17;
  localparam logic [4:0] ALU_IMM = 5'd18;

  typedef enum logic [1:0] {
    PC_PLUS1 = 2'd0,
    PC_IMM   = 2'd1,
    PC_JUMP  = 2'd2,
    PC_REG   = 2'd3
  } pc_src_e;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_IN  = 2'd2
  } wb_sel_e;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_MEMORY,
    S_WRITEBACK,
    S_HALT,
    S_WAIT_IN
  } state_e;

  typedef enum logic [3:0] {
    CLS_ALU,
    CLS_LOAD,
    CLS_STORE,
    CLS_BT,
    CLS_BF,
    CLS_J,
    CLS_JR,
    CLS_HALT,
    CLS_IN,
    CLS_NOP,
    CLS_ILLEGAL
  } instr_cls_e;

endpackage

// File: rtl/cu_decode.sv
// Combinational opcode decoder: instruction class plus the ALU operation and
// operand-2 source that EXECUTE will present to the ALU.
module cu_decode
  import cu_pkg::*;
(
  input  logic [5:0]  opcode_i,
  output instr_cls_e  cls_o,
  output logic [4:0]  alu_op_o,
  output logic        alu_src_o
);

  // Map the opcode to its class and ALU controls.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
    cls_o     = CLS_ILLEGAL;
    alu_op_o  = ALU_NOP;
    alu_src_o = 1'b0;
    if (opcode_i <= OP_R_LAST) begin
      cls_o    = CLS_ALU;
      alu_op_o = opcode_i[4:0];
    end else begin
      case (opcode_i)
        OP_NOP:  cls_o = CLS_NOP;
        OP_ADDI: begin cls_o = CLS_ALU;   alu_op_o = ALU_ADD; alu_src_o = 1'b1; end
        OP_SUBI: begin cls_o = CLS_ALU;   alu_op_o = ALU_SUB; alu_src_o = 1'b1; end
        OP_LI:   begin cls_o = CLS_ALU;   alu_op_o = ALU_IMM; alu_src_o = 1'b1; end
        OP_LW:   begin cls_o = CLS_LOAD;  alu_op_o = ALU_ADD; alu_src_o = 1'b1; end
        OP_SW:   begin cls_o = CLS_STORE; alu_op_o = ALU_ADD; alu_src_o = 1'b1; end
        OP_BT:   begin cls_o = CLS_BT;    alu_op_o = ALU_CMP; end
        OP_BF:   begin cls_o = CLS_BF;    alu_op_o = ALU_CMP; end
        OP_J:    cls_o = CLS_J;
        OP_JR:   cls_o = CLS_JR;
        OP_HLT:  cls_o = CLS_HALT;
        OP_IN:   cls_o = CLS_IN;
        default: cls_o = CLS_ILLEGAL;
      endcase
    end
  end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle control unit: FETCH/DECODE/EXECUTE sequencer with memory wait
// and timeout, input-port wait, halt, and illegal-opcode fault reporting.
module control_unit
  import cu_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic        Fast_Clock,
  input  logic        Reset_n,
  input  logic [31:0] Instruction,
  input  logic        True,
  input  logic        Mem_Ready,
  input  logic        In_Valid,
  input  logic        Resume,
  output logic        Instr_Load,
  output logic        PC_Write,
  output logic [1:0]  PC_Src,
  output logic [4:0]  ALU_Op,
  output logic        ALU_Src,
  output logic        Reg_Write,
  output logic        Mem_Read,
  output logic        Mem_Write,
  output logic [1:0]  WB_Sel,
  output logic        In_Ack,
  output logic        Halted,
  output logic        Fault
);

  localparam int CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(MEM_TIMEOUT);

  state_e           state_q, state_d;
  logic             run_q, run_d;        // low until the first edge after reset
  logic [5:0]       opcode_q, opcode_d;  // opcode captured when the IR loads
  logic [4:0]       alu_op_q, alu_op_d;
  logic             alu_src_q, alu_src_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

  instr_cls_e dec_cls;
  logic [4:0] dec_alu_op;
  logic       dec_alu_src;

  // Operand fields go straight to the datapath; only the opcode is used here.
  logic unused_instr_bits;
  assign unused_instr_bits = ^Instruction[25:0];

  assign ALU_Op  = alu_op_q;
  assign ALU_Src = alu_src_q;

  cu_decode u_decode (
    .opcode_i  (opcode_q),
    .cls_o     (dec_cls),
    .alu_op_o  (dec_alu_op),
    .alu_src_o (dec_alu_src)
  );

  // State, captured opcode, registered ALU controls and memory wait counter.
  always_ff @(posedge Fast_Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= S_FETCH;
      run_q      <= 1'b0;
      opcode_q   <= OP_NOP;
      alu_op_q   <= ALU_NOP;
      alu_src_q  <= 1'b0;
      wait_cnt_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so all registers update together from pre-edge values.
      state_q    <= state_d;
      run_q      <= run_d;
      opcode_q   <= opcode_d;
      alu_op_q   <= alu_op_d;
      alu_src_q  <= alu_src_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Next-state logic and per-state control outputs.
  always_comb begin
    state_d    = state_q;
    run_d      = 1'b1;
    opcode_d   = opcode_q;
    alu_op_d   = ALU_NOP;
    alu_src_d  = 1'b0;
    wait_cnt_d = '0;
    Instr_Load = 1'b0;
    PC_Write   = 1'b0;
    PC_Src     = PC_PLUS1;
    Reg_Write  = 1'b0;
    Mem_Read   = 1'b0;
    Mem_Write  = 1'b0;
    WB_Sel     = WB_ALU;
    In_Ack     = 1'b0;
    Halted     = 1'b0;
    Fault      = 1'b0;

    case (state_q)
      S_FETCH: begin
        // The first edge after reset only arms the sequencer.
        if (run_q) begin
          Instr_Load = 1'b1;
          PC_Write   = 1'b1;
          PC_Src     = PC_PLUS1;
          opcode_d   = Instruction[31:26];
          state_d    = S_DECODE;
        end
      end

      S_DECODE: begin
        alu_op_d  = dec_alu_op;
        alu_src_d = dec_alu_src;
        state_d   = S_EXECUTE;
      end

      S_EXECUTE: begin
        state_d = S_FETCH;
        case (dec_cls)
          CLS_ALU:             state_d = S_WRITEBACK;
          CLS_LOAD, CLS_STORE: state_d = S_MEMORY;
          CLS_BT: begin
            if (True) begin
              PC_Write = 1'b1;
              PC_Src   = PC_IMM;
            end
          end
          CLS_BF: begin
            if (!True) begin
              PC_Write = 1'b1;
              PC_Src   = PC_IMM;
            end
          end
          CLS_J: begin
            PC_Write = 1'b1;
            PC_Src   = PC_JUMP;
          end
          CLS_JR: begin
            PC_Write = 1'b1;
            PC_Src   = PC_REG;
          end
          CLS_HALT:    state_d = S_HALT;
          CLS_IN:      state_d = S_WAIT_IN;
          CLS_ILLEGAL: Fault   = 1'b1;
          default:     ;
        endcase
      end

      S_MEMORY: begin
        if (wait_cnt_q == TIMEOUT_CNT) begin
          // Give up: requests drop, fault pulses, no writeback.
          Fault   = 1'b1;
          state_d = S_FETCH;
        end else begin
          Mem_Read  = (dec_cls == CLS_LOAD);
          Mem_Write = (dec_cls == CLS_STORE);
          if (Mem_Ready) begin
            state_d = (dec_cls == CLS_LOAD) ? S_WRITEBACK : S_FETCH;
          end else begin
            wait_cnt_d = wait_cnt_q + CNT_W'(1);
          end
        end
      end

      S_WRITEBACK: begin
        Reg_Write = 1'b1;
        WB_Sel    = (dec_cls == CLS_LOAD) ? WB_MEM : WB_ALU;
        state_d   = S_FETCH;
      end

      S_WAIT_IN: begin
        if (In_Valid) begin
          In_Ack    = 1'b1;
          Reg_Write = 1'b1;
          WB_Sel    = WB_IN;
          state_d   = S_FETCH;
        end
      end

      S_HALT: begin
        Halted = 1'b1;
        if (Resume) state_d = S_FETCH;
      end

      default: state_d = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: each driven cycle pushes the expected
// output vector, and a falling-edge monitor pops and compares it.
module tb_control_unit;

  localparam int TIMEOUT = 4;

  logic        Fast_Clock = 1'b0;
  logic        Reset_n    = 1'b0;
  logic [31:0] Instruction = '0;
  logic        True      = 1'b0;
  logic        Mem_Ready = 1'b0;
  logic        In_Valid  = 1'b0;
  logic        Resume    = 1'b0;
  logic        Instr_Load, PC_Write, ALU_Src, Reg_Write, Mem_Read, Mem_Write;
  logic        In_Ack, Halted, Fault;
  logic [1:0]  PC_Src, WB_Sel;
  logic [4:0]  ALU_Op;

  control_unit #(.MEM_TIMEOUT(TIMEOUT)) dut (
    .Fast_Clock  (Fast_Clock),
    .Reset_n     (Reset_n),
    .Instruction (Instruction),
    .True        (True),
    .Mem_Ready   (Mem_Ready),
    .In_Valid    (In_Valid),
    .Resume      (Resume),
    .Instr_Load  (Instr_Load),
    .PC_Write    (PC_Write),
    .PC_Src      (PC_Src),
    .ALU_Op      (ALU_Op),
    .ALU_Src     (ALU_Src),
    .Reg_Write   (Reg_Write),
    .Mem_Read    (Mem_Read),
    .Mem_Write   (Mem_Write),
    .WB_Sel      (WB_Sel),
    .In_Ack      (In_Ack),
    .Halted      (Halted),
    .Fault       (Fault)
  );

  always #5 Fast_Clock = ~Fast_Clock;

  // Packed view: {IL, PCW, PCSrc[2], ALUOp[5], ALUSrc, RW, MR, MW, WB[2], Ack, Halt, Fault}
  logic [18:0] obs_vec;
  assign obs_vec = {Instr_Load, PC_Write, PC_Src, ALU_Op, ALU_Src, Reg_Write,
                    Mem_Read, Mem_Write, WB_Sel, In_Ack, Halted, Fault};

  int n_checks = 0;
  int n_errors = 0;

  logic [18:0] exp_vec_q[$];
  string       exp_tag_q[$];

  logic [18:0] v_idle, v_fetch;
  logic [31:0] junk_word;

  task automatic check(input string tag, input logic [18:0] obs, input logic [18:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed 0x%05h expected 0x%05h", tag, obs, exp);
    end
  endtask

  function automatic logic [18:0] mk(input logic il, input logic pw, input logic [1:0] pcs,
                                     input logic [4:0] aop, input logic asrc, input logic rw,
                                     input logic mr, input logic mw, input logic [1:0] wb,
                                     input logic ack, input logic hlt, input logic flt);
    return {il, pw, pcs, aop, asrc, rw, mr, mw, wb, ack, hlt, flt};
  endfunction

  function automatic logic [31:0] iw(input logic [5:0] op);
    return {op, 5'd3, 5'd4, 16'h00A5};
  endfunction

  // One cycle of stimulus plus the outputs that cycle must show.
  task automatic step(input string tag, input logic [31:0] instr, input logic tru,
                      input logic rdy, input logic inv, input logic res,
                      input logic [18:0] exp);
    @(posedge Fast_Clock);
    #1;
    Instruction = instr;
    True        = tru;
    Mem_Ready   = rdy;
    In_Valid    = inv;
    Resume      = res;
    exp_tag_q.push_back(tag);
    exp_vec_q.push_back(exp);
  endtask

  // FETCH then DECODE; stray handshakes during DECODE must be ignored.
  task automatic fd(input string tag, input logic [5:0] op);
    step({tag, "/fetch"}, iw(op), 1'b0, 1'b0, 1'b0, 1'b0, v_fetch);
    step({tag, "/decode"}, junk_word, 1'b1, 1'b1, 1'b1, 1'b1, v_idle);
  endtask

  task automatic run_alu(input string tag, input logic [5:0] op, input logic [4:0] aop,
                         input logic asrc);
    fd(tag, op);
    step({tag, "/exec"}, junk_word, 1'b0, 1'b0, 1'b0, 1'b0,
         mk(0, 0, 2'd0, aop, asrc, 0, 0, 0, 2'd0, 0, 0, 0));
    step({tag, "/wb"}, junk_word, 1'b0, 1'b0, 1'b0, 1'b0,
         mk(0, 0, 2'd0, 5'd17, 0, 1, 0, 0, 2'd0, 0, 0, 0));
  endtask

  task automatic run_branch(input string tag, input logic [5:0] op, input logic tru,
                            input logic taken);
    fd(tag, op);
    step({tag, "/exec"}, junk_word, tru, 1'b0, 1'b0, 1'b0,
         mk(0, taken, taken ? 2'd1 : 2'd0, 5'd11, 0, 0, 0, 0, 2'd0, 0, 0, 0));
  endtask

  task automatic run_jump(input string tag, input logic [5:0] op, input logic [1:0] src);
    fd(tag, op);
    step({tag, "/exec"}, junk_word, 1'b0, 1'b0, 1'b0, 1'b0,
         mk(0, 1, src, 5'd17, 0, 0, 0, 0, 2'd0, 0, 0, 0));
  endtask

  task automatic run_lw(input string tag, input int ready_cycle);
    fd(tag, 6'd22);
    step({tag, "/exec"}, junk_word, 1'b0, 1'b0, 1'b0, 1'b0,
         mk(0, 0, 2'd0, 5'd0, 1, 0, 0, 0, 2'd0, 0, 0, 0));
    for (int i = 1; i <= ready_cycle; i++) begin
      step({tag, "/mem"}, junk_word, 1'b0, (i == ready_cycle), 1'b0, 1'b0,
           mk(0, 0, 2'd0, 5'd17, 0, 0, 1, 0, 2'd0, 0, 0, 0));
    end
    step({tag, "/wb"}, junk_word, 1'b0, 1'b0, 1'b0, 1'b0,
         mk(0, 0, 2'd0, 5'd17, 0, 1, 0, 0, 2'd1, 0, 0, 0));
  endtask

  task automatic run_sw(input string tag, input logic ready_now);
    fd(tag, 6'd23);
    step({tag, "/exec"}, junk_word, 1'b0, 1'b0, 1'b0, 1'b0,
         mk(0, 0, 2'd0, 5'd0, 1, 0, 0, 0, 2'd0, 0, 0, 0));
    if (ready_now) begin
      step({tag, "/mem"}, junk_word, 1'b0, 1'b1, 1'b0, 1'b0,
           mk(0, 0, 2'd0, 5'd17, 0, 0, 0, 1, 2'd0, 0, 0, 0));
    end else begin
      for (int i = 0; i < TIMEOUT; i++) begin
        step({tag, "/mem"}, junk_word, 1'b0, 1'b0, 1'b0, 1'b0,
             mk(0, 0, 2'd0, 5'd17, 0, 0, 0, 1, 2'd0, 0, 0, 0));
      end
      step({tag, "/timeout"}, junk_word, 1'b0, 1'b0, 1'b0, 1'b0,
           mk(0, 0, 2'd0, 5'd17, 0, 0, 0, 0, 2'd0, 0, 0, 1));
    end
  endtask

  task automatic run_in(input string tag, input int waits);
    fd(tag, 6'd29);
    step({tag, "/exec"}, junk_word, 1'b0, 1'b0, 1'b0, 1'b0, v_idle);
    for (int i = 0; i < waits; i++) begin
      step({tag, "/wait"}, junk_word, 1'b0, 1'b0, 1'b0, 1'b0, v_idle);
    end
    step({tag, "/ack"}, junk_word, 1'b0, 1'b0, 1'b1, 1'b0,
         mk(0, 0, 2'd0, 5'd17, 0, 1, 0, 0, 2'd2, 1, 0, 0));
  endtask

  // Halt for n cycles; Resume is raised in the last one when resume_last is set.
  task automatic run_hlt(input string tag, input int n, input logic resume_last);
    fd(tag, 6'd28);
    step({tag, "/exec"}, junk_word, 1'b0, 1'b0, 1'b0, 1'b0, v_idle);
    for (int i = 1; i <= n; i++) begin
      step({tag, "/halt"}, junk_word, 1'b0, 1'b0, 1'b0, resume_last && (i == n),
           mk(0, 0, 2'd0, 5'd17, 0, 0, 0, 0, 2'd0, 0, 1, 0));
    end
  endtask

  task automatic run_simple(input string tag, input logic [5:0] op, input logic flt);
    fd(tag, op);
    step({tag, "/exec"}, junk_word, 1'b0, 1'b0, 1'b0, 1'b0,
         mk(0, 0, 2'd0, 5'd17, 0, 0, 0, 0, 2'd0, 0, 0, flt));
  endtask

  // Pulse reset mid-cycle, hold it across an edge with every handshake high.
  task automatic async_reset(input string tag);
    @(negedge Fast_Clock);
    #1;
    Reset_n   = 1'b0;
    Resume    = 1'b1;
    In_Valid  = 1'b1;
    Mem_Ready = 1'b1;
    True      = 1'b1;
    #1 check({tag, "/async"}, obs_vec, v_idle);
    @(posedge Fast_Clock);
    #1 check({tag, "/held"}, obs_vec, v_idle);
    @(negedge Fast_Clock);
    Reset_n   = 1'b1;
    Resume    = 1'b0;
    In_Valid  = 1'b0;
    Mem_Ready = 1'b0;
    True      = 1'b0;
    #1 check({tag, "/released"}, obs_vec, v_idle);
  endtask

  // Scoreboard monitor: compare each expected cycle away from the rising edge.
  always @(negedge Fast_Clock) begin
    if (exp_vec_q.size() > 0) begin
      check(exp_tag_q.pop_front(), obs_vec, exp_vec_q.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    v_idle    = mk(0, 0, 2'd0, 5'd17, 0, 0, 0, 0, 2'd0, 0, 0, 0);
    v_fetch   = mk(1, 1, 2'd0, 5'd17, 0, 0, 0, 0, 2'd0, 0, 0, 0);
    junk_word = 32'hFFFF_FFFF;

    // Reset dominates over every handshake input.
    Resume = 1'b1; In_Valid = 1'b1; Mem_Ready = 1'b1;
    repeat (2) @(posedge Fast_Clock);
    #1 check("reset", obs_vec, v_idle);
    @(negedge Fast_Clock);
    Reset_n = 1'b1; Resume = 1'b0; In_Valid = 1'b0; Mem_Ready = 1'b0;
    #1 check("reset_release", obs_vec, v_idle);

    run_alu("add", 6'd0, 5'd0, 1'b0);
    run_alu("r13", 6'd13, 5'd13, 1'b0);
    run_alu("r16", 6'd16, 5'd16, 1'b0);
    run_alu("addi", 6'd19, 5'd0, 1'b1);
    run_alu("subi", 6'd20, 5'd1, 1'b1);
    run_alu("li", 6'd21, 5'd18, 1'b1);

    run_branch("bt_true", 6'd24, 1'b1, 1'b1);
    run_branch("bt_false", 6'd24, 1'b0, 1'b0);
    run_branch("bf_false", 6'd25, 1'b0, 1'b1);
    run_branch("bf_true", 6'd25, 1'b1, 1'b0);

    run_jump("j", 6'd26, 2'd2);
    run_jump("jr", 6'd27, 2'd3);

    run_lw("lw_rdy3", 3);
    run_lw("lw_rdy1", 1);
    run_sw("sw_timeout", 1'b0);
    run_sw("sw_rdy", 1'b1);

    run_simple("nop", 6'd17, 1'b0);
    run_in("in_wait2", 2);
    run_in("in_now", 0);
    run_hlt("hlt10", 10, 1'b1);

    run_simple("ill63", 6'd63, 1'b1);
    run_alu("add_after_ill", 6'd0, 5'd0, 1'b0);
    run_simple("ill18", 6'd18, 1'b1);
    run_simple("ill30", 6'd30, 1'b1);

    // Reset while the ALU controls are live.
    fd("rst_exec", 6'd19);
    step("rst_exec/exec", junk_word, 1'b0, 1'b0, 1'b0, 1'b0,
         mk(0, 0, 2'd0, 5'd0, 1, 0, 0, 0, 2'd0, 0, 0, 0));
    async_reset("rst_exec");
    run_alu("add_after_rst", 6'd0, 5'd0, 1'b0);

    // Reset in the middle of a memory wait.
    fd("rst_mem", 6'd22);
    step("rst_mem/exec", junk_word, 1'b0, 1'b0, 1'b0, 1'b0,
         mk(0, 0, 2'd0, 5'd0, 1, 0, 0, 0, 2'd0, 0, 0, 0));
    step("rst_mem/mem", junk_word, 1'b0, 1'b0, 1'b0, 1'b0,
         mk(0, 0, 2'd0, 5'd17, 0, 0, 1, 0, 2'd0, 0, 0, 0));
    async_reset("rst_mem");
    run_lw("lw_after_rst", 2);

    // Reset while halted.
    run_hlt("rst_halt", 3, 1'b0);
    async_reset("rst_halt");
    run_alu("subi_after_rst", 6'd20, 5'd1, 1'b1);

    repeat (2) @(posedge Fast_Clock);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
